recovery_sequencer: RTL and testbench
=====================================

RECOVERY_SEQUENCER -- requirements
Module: recovery_sequencer

Interface
REQ-001 SHALL have parameters: XLEN=32, instruction/data width; VOTER_W=3, voter state width (one bit per core); RESTORE_MASK=3'b111, enables restoring rd/rs1/rs2 (bits 0/1/2); IMM_BASE=7'd0, upper immediate bits of the restore load; LOAD_FUNCT3=3'b011, funct3 of the restore load; MAX_RETRY=3, replay attempts before fail; CHECK_CYCLES=4, post-replay observation window.
REQ-002 clk  in  1  single clock; all state on rising edge.
REQ-003 rst_in  in  1  reset, asynchronous, active-low.
REQ-004 voter_state  in  VOTER_W  per-core disagreement flags; all-zero means agreement.
REQ-005 rd_instr  in  XLEN  majority-voted instruction currently at the read stage.
REQ-006 rollback_ready  in  1  core pipeline accepts rollback_instr.
REQ-007 rollback_instr  out  XLEN  injected restore/replay instruction.
REQ-008 rollback_valid  out  1  rollback_instr is valid.
REQ-009 mux_instr_sel, mux_data_sel  out  1 each  select rollback path for instruction and data muxes.
REQ-010 core_hold  out  1  freezes normal fetch.
REQ-011 recovery_mode  out  1  sequencer not IDLE.
REQ-012 recovery_fail  out  1  sticky unrecoverable-fault flag.
REQ-013 retry_cnt  out  $clog2(MAX_RETRY+1)  current attempt count.

Function
REQ-014 fault SHALL be |voter_state; recovery SHALL start only on a registered 0->1 edge of fault while in IDLE.
REQ-015 States SHALL be IDLE, CAPTURE, RST_RD, RST_RS1, RST_RS2, REPLAY, CHECK, FAIL.
REQ-016 CAPTURE SHALL latch rd_instr into a saved register in one cycle, then go to RST_RD.
REQ-017 Restore instruction for register r SHALL be {IMM_BASE, r[4:0], 5'b0, LOAD_FUNCT3, r[4:0], 7'b0000011}; r is saved[11:7], [19:15], [24:20] for RST_RD, RST_RS1, RST_RS2 respectively.
REQ-018 A RST_* state SHALL be skipped in zero cycles when its RESTORE_MASK bit is 0 or r==0.
REQ-019 In RST_* and REPLAY, rollback_valid SHALL be 1 with rollback_instr stable until rollback_valid&&rollback_ready, and SHALL advance on that cycle; REPLAY drives the saved instruction.
REQ-020 After REPLAY handshake, CHECK SHALL count CHECK_CYCLES cycles with rollback_valid=0; fault during the window ends it immediately.
REQ-021 CHECK with no fault SHALL go to IDLE and clear retry_cnt; with fault, retry_cnt+1; if the new count equals MAX_RETRY go to FAIL, else go to RST_RD reusing the saved instruction (no recapture).
REQ-022 Faults in CAPTURE, RST_*, REPLAY SHALL be ignored.
REQ-023 FAIL SHALL hold recovery_fail=1, core_hold=1, rollback_valid=0 until reset.
REQ-024 core_hold, recovery_mode, mux_instr_sel, mux_data_sel SHALL be 1 in every state except IDLE; all outputs SHALL be registered or decoded from state only.
REQ-025 Minimum recovery latency (all ready, 3 restores, clean check) SHALL be 1+3+1+CHECK_CYCLES cycles from the edge-detect cycle.

Reset
REQ-026 rst_in low SHALL asynchronously force IDLE, all outputs 0, retry_cnt 0, saved instruction 0, fault-edge register 0, including mid-sequence and in FAIL.
REQ-027 On reset release with fault already high, no recovery SHALL start until fault falls and rises again.

Structure
REQ-028 State encoding, RV opcode/field position constants and the restore-instruction build function SHALL live in shared package rv_tmr_pkg.
REQ-029 A sub-module fault_edge_det (fault synchroniser/rising-edge detector) SHALL be instantiated; the rest is one FSM plus counters.

Verification
REQ-030 voter_state 000->010, rd_instr=0x007302B3, ready=1 -> rollback_instr 0x00503283, 0x00603303, 0x00703383, 0x007302B3 on consecutive handshakes, then IDLE after 4 clean cycles, retry_cnt=0.
REQ-031 Same, rollback_ready low 3 cycles during RST_RS1 -> 0x00603303 held stable with valid=1 for those cycles; no skipped or duplicated instruction.
REQ-032 rd_instr=0x00000013 (addi x0,x0,0) -> all restores skipped, first valid instruction is 0x00000013 replay.
REQ-033 Fault reasserted in each CHECK -> retry_cnt 1, 2, then FAIL with recovery_fail=1, core_hold=1 until rst_in low.
REQ-034 rst_in low during RST_RS2 -> all outputs 0 immediately; after release, held fault does not retrigger.

Source files
------------

// File: rtl/rv_tmr_pkg.sv
// Shared definitions for the TMR recovery path: sequencer state encoding,
// RV32 field positions and the restore-load instruction builder.
package rv_tmr_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CAPTURE,
    ST_RST_RD,
    ST_RST_RS1,
    ST_RST_RS2,
    ST_REPLAY,
    ST_CHECK,
    ST_FAIL
  } rec_state_t;

  localparam int RV_OPC_LSB = 0;
  localparam int RV_RD_LSB  = 7;
  localparam int RV_F3_LSB  = 12;
  localparam int RV_RS1_LSB = 15;
  localparam int RV_RS2_LSB = 20;
  localparam int RV_IMM_LSB = 25;

  localparam logic [6:0] RV_OPC_LOAD = 7'b0000011;

  // idx 0/1/2 selects the rd/rs1/rs2 field of an instruction.
  function automatic logic [4:0] rv_reg_field(input logic [31:0] instr, input logic [1:0] idx);
    case (idx)
      2'd0:    return instr[RV_RD_LSB +: 5];
      2'd1:    return instr[RV_RS1_LSB +: 5];
      default: return instr[RV_RS2_LSB +: 5];
    endcase
  endfunction

  function automatic rec_state_t rv_restore_state(input logic [1:0] idx);
    case (idx)
      2'd0:    return ST_RST_RD;
      2'd1:    return ST_RST_RS1;
      default: return ST_RST_RS2;
    endcase
  endfunction

  // Load that reloads register r from the checkpoint area: the same index
  // appears in both the destination and the immediate's low field.
  function automatic logic [31:0] rv_restore_instr(input logic [6:0] imm_hi,
                                                   input logic [2:0] funct3,
                                                   input logic [4:0] r);
    logic [31:0] w;
    w = '0;
    w[RV_IMM_LSB +: 7] = imm_hi;
    w[RV_RS2_LSB +: 5] = r;
    w[RV_F3_LSB  +: 3] = funct3;
    w[RV_RD_LSB  +: 5] = r;
    w[RV_OPC_LSB +: 7] = RV_OPC_LOAD;
    return w;
  endfunction

endpackage

// File: rtl/fault_edge_det.sv
// Registered rising-edge detector for the voter fault flag; it stays disarmed
// for the first clock after reset so a fault already present cannot trigger.
module fault_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic fault,
  output logic fault_rise
);

  logic fault_q;
  logic armed_q;

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault_q <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      fault_q <= fault;
      armed_q <= 1'b1;
    end
  end

  assign fault_rise = armed_q & fault & ~fault_q;

endmodule

// File: rtl/recovery_sequencer.sv
// Rollback sequencer: on a voter disagreement it captures the read-stage
// instruction, restores its registers, replays it and watches for a clean window.
module recovery_sequencer
  import rv_tmr_pkg::*;
#(
  parameter int         XLEN         = 32,
  parameter int         VOTER_W      = 3,
  parameter logic [2:0] RESTORE_MASK = 3'b111,
  parameter logic [6:0] IMM_BASE     = 7'd0,
  parameter logic [2:0] LOAD_FUNCT3  = 3'b011,
  parameter int         MAX_RETRY    = 3,
  parameter int         CHECK_CYCLES = 4
) (
  input  logic                           clk,
  input  logic                           rst_in,
  input  logic [VOTER_W-1:0]             voter_state,
  input  logic [XLEN-1:0]                rd_instr,
  input  logic                           rollback_ready,
  output logic [XLEN-1:0]                rollback_instr,
  output logic                           rollback_valid,
  output logic                           mux_instr_sel,
  output logic                           mux_data_sel,
  output logic                           core_hold,
  output logic                           recovery_mode,
  output logic                           recovery_fail,
  output logic [$clog2(MAX_RETRY+1)-1:0] retry_cnt
);

  localparam int RW = $clog2(MAX_RETRY + 1);
  localparam int CW = (CHECK_CYCLES > 1) ? $clog2(CHECK_CYCLES) : 1;

  rec_state_t      state_q, state_d;
  logic [XLEN-1:0] saved_q, saved_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] src;
  logic [RW-1:0]   retry_q, retry_d;
  logic [CW-1:0]   chk_q, chk_d;
  logic            fault, fault_rise, handshake;

  assign fault = |voter_state;

  fault_edge_det u_edge (
    .clk       (clk),
    .rst_n     (rst_in),
    .fault     (fault),
    .fault_rise(fault_rise)
  );

  // First restore stage at or after 'start' that has work to do; disabled or
  // x0 stages are skipped without spending a cycle.
  function automatic rec_state_t first_active(input int start, input logic [XLEN-1:0] instr);
    rec_state_t nxt;
    nxt = ST_REPLAY;
    for (int i = 2; i >= 0; i--) begin
      if (i >= start && RESTORE_MASK[i[1:0]] && rv_reg_field(instr[31:0], i[1:0]) != 5'd0)
        nxt = rv_restore_state(i[1:0]);
    end
    return nxt;
  endfunction

  function automatic logic [XLEN-1:0] rollback_word(input rec_state_t s, input logic [XLEN-1:0] instr);
    logic [XLEN-1:0] w;
    case (s)
      ST_RST_RD:  w = XLEN'(rv_restore_instr(IMM_BASE, LOAD_FUNCT3, rv_reg_field(instr[31:0], 2'd0)));
      ST_RST_RS1: w = XLEN'(rv_restore_instr(IMM_BASE, LOAD_FUNCT3, rv_reg_field(instr[31:0], 2'd1)));
      ST_RST_RS2: w = XLEN'(rv_restore_instr(IMM_BASE, LOAD_FUNCT3, rv_reg_field(instr[31:0], 2'd2)));
      ST_REPLAY:  w = instr;
      default:    w = '0;
    endcase
    return w;
  endfunction

  assign handshake = rollback_valid && rollback_ready;

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    saved_d = saved_q;
    retry_d = retry_q;
    chk_d   = chk_q;
    src     = saved_q;
    case (state_q)
      ST_IDLE:    if (fault_rise) state_d = ST_CAPTURE;
      ST_CAPTURE: begin
        saved_d = rd_instr;
        src     = rd_instr;
        state_d = first_active(0, rd_instr);
      end
      ST_RST_RD:  if (handshake) state_d = first_active(1, saved_q);
      ST_RST_RS1: if (handshake) state_d = first_active(2, saved_q);
      ST_RST_RS2: if (handshake) state_d = ST_REPLAY;
      ST_REPLAY: begin
        if (handshake) begin
          state_d = ST_CHECK;
          chk_d   = '0;
        end
      end
      ST_CHECK: begin
        if (fault) begin
          retry_d = retry_q + RW'(1);
          state_d = (retry_d == RW'(MAX_RETRY)) ? ST_FAIL : first_active(0, saved_q);
        end else if (chk_q == CW'(CHECK_CYCLES - 1)) begin
          state_d = ST_IDLE;
          retry_d = '0;
        end else begin
          chk_d = chk_q + CW'(1);
        end
      end
      ST_FAIL:    state_d = ST_FAIL;
      default:    state_d = ST_IDLE;
    endcase
    // Loaded on entry so the word is already stable in the cycle valid rises.
    instr_d = rollback_word(state_d, src);
  end

  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= ST_IDLE;
      // NOTE: saved_q is a plain register, not a memory array, so it is
      // cleared with the rest; a new sequence can never see a stale capture.
      saved_q <= '0;
      instr_q <= '0;
      retry_q <= '0;
      chk_q   <= '0;
    end else begin
      state_q <= state_d;
      saved_q <= saved_d;
      instr_q <= instr_d;
      retry_q <= retry_d;
      chk_q   <= chk_d;
    end
  end

  assign rollback_instr = instr_q;
  assign rollback_valid = (state_q == ST_RST_RD) || (state_q == ST_RST_RS1) ||
                          (state_q == ST_RST_RS2) || (state_q == ST_REPLAY);
  assign recovery_mode  = (state_q != ST_IDLE);
  assign core_hold      = recovery_mode;
  assign mux_instr_sel  = recovery_mode;
  assign mux_data_sel   = recovery_mode;
  assign recovery_fail  = (state_q == ST_FAIL);
  assign retry_cnt      = retry_q;

endmodule

// File: tb/tb_recovery_sequencer.sv
// Self-checking bench for recovery_sequencer: a transaction-level model of the
// expected rollback stream plus per-cycle invariants and directed scenarios.
module tb_recovery_sequencer;

  localparam int CHECK_CYCLES = 4;

  logic        clk = 1'b0;
  logic        rst_in = 1'b0;
  logic [2:0]  voter_state = '0;
  logic [31:0] rd_instr = '0;
  logic        rollback_ready = 1'b1;
  logic [31:0] rollback_instr;
  logic        rollback_valid, mux_instr_sel, mux_data_sel;
  logic        core_hold, recovery_mode, recovery_fail;
  logic [1:0]  retry_cnt;

  recovery_sequencer #(
    .XLEN(32), .VOTER_W(3), .RESTORE_MASK(3'b111), .IMM_BASE(7'd0),
    .LOAD_FUNCT3(3'b011), .MAX_RETRY(3), .CHECK_CYCLES(CHECK_CYCLES)
  ) dut (
    .clk           (clk),
    .rst_in        (rst_in),
    .voter_state   (voter_state),
    .rd_instr      (rd_instr),
    .rollback_ready(rollback_ready),
    .rollback_instr(rollback_instr),
    .rollback_valid(rollback_valid),
    .mux_instr_sel (mux_instr_sel),
    .mux_data_sel  (mux_data_sel),
    .core_hold     (core_hold),
    .recovery_mode (recovery_mode),
    .recovery_fail (recovery_fail),
    .retry_cnt     (retry_cnt)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_q[$];
  logic [31:0] log_q[$];
  int          mode_cycles = 0;
  int          stall_cycles = 0;
  int          hs_count = 0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_instr = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic fail_timeout(input string name);
    checks++;
    failures++;
    $display("FAIL %s: timed out waiting for the sequencer", name);
  endtask

  // Model: restore loads for each nonzero rd/rs1/rs2, then the instruction itself.
  function automatic logic [31:0] restore_word(input logic [4:0] r);
    return (32'(r) << 20) | (32'd3 << 12) | (32'(r) << 7) | 32'd3;
  endfunction

  function automatic int push_expected(input logic [31:0] instr);
    logic [4:0] regs[3];
    int n = 0;
    regs[0] = instr[11:7];
    regs[1] = instr[19:15];
    regs[2] = instr[24:20];
    for (int i = 0; i < 3; i++) begin
      if (regs[i] != 5'd0) begin
        exp_q.push_back(restore_word(regs[i]));
        n++;
      end
    end
    exp_q.push_back(instr);
    return n;
  endfunction

  // Per-cycle compare against the model and the structural invariants.
  always @(negedge clk) begin
    if (!rst_in) begin
      prev_stall = 1'b0;
    end else begin
      check_bit("hold_vs_mode", core_hold, recovery_mode);
      check_bit("mux_instr_vs_mode", mux_instr_sel, recovery_mode);
      check_bit("mux_data_vs_mode", mux_data_sel, recovery_mode);
      if (rollback_valid) check_bit("valid_in_mode", recovery_mode, 1'b1);
      if (recovery_fail) begin
        check_bit("fail_hold", core_hold, 1'b1);
        check_bit("fail_no_valid", rollback_valid, 1'b0);
      end
      if (prev_stall) begin
        check_bit("stall_valid", rollback_valid, 1'b1);
        check("stall_instr", rollback_instr, prev_instr);
      end
      if (recovery_mode) mode_cycles++;
      if (rollback_valid && !rollback_ready) stall_cycles++;
      if (rollback_valid && rollback_ready) begin
        log_q.push_back(rollback_instr);
        hs_count++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_handshake: got 0x%08h with nothing expected", rollback_instr);
        end else begin
          check("handshake_word", rollback_instr, exp_q.pop_front());
        end
      end
      prev_stall = rollback_valid && !rollback_ready;
      prev_instr = rollback_instr;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic begin_scenario(input logic [31:0] instr, output int n_restores);
    rd_instr = instr;
    log_q.delete();
    mode_cycles = 0;
    stall_cycles = 0;
    hs_count = 0;
    n_restores = push_expected(instr);
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!(mode_cycles > 0 && !recovery_mode) && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 100) fail_timeout(name);
  endtask

  task automatic check_log(input string name, input logic [31:0] lit[$]);
    check({name, "_count"}, 32'(log_q.size()), 32'(lit.size()));
    foreach (lit[i]) begin
      if (i < log_q.size()) check($sformatf("%s_word%0d", name, i), log_q[i], lit[i]);
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_instr"}, rollback_instr, 32'h0);
    check_bit({tag, "_valid"}, rollback_valid, 1'b0);
    check_bit({tag, "_mux_i"}, mux_instr_sel, 1'b0);
    check_bit({tag, "_mux_d"}, mux_data_sel, 1'b0);
    check_bit({tag, "_hold"}, core_hold, 1'b0);
    check_bit({tag, "_mode"}, recovery_mode, 1'b0);
    check_bit({tag, "_fail"}, recovery_fail, 1'b0);
    check({tag, "_retry"}, 32'(retry_cnt), 32'h0);
  endtask

  task automatic finish_scenario(input string name, input int exp_mode, input logic [31:0] lit[$]);
    wait_done(name);
    check({name, "_mode_cycles"}, 32'(mode_cycles), 32'(exp_mode));
    check({name, "_retry"}, 32'(retry_cnt), 32'h0);
    check({name, "_queue_empty"}, 32'(exp_q.size()), 32'h0);
    check_log(name, lit);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] lit[$];
    int nr;

    tick(2);
    check_zero_outputs("in_reset");
    rst_in = 1'b1;
    tick(3);
    check_zero_outputs("after_reset");

    // Full restore of rd/rs1/rs2 and replay, all ready.
    begin_scenario(32'h007302B3, nr);
    voter_state = 3'b010;
    tick(2);
    voter_state = 3'b000;
    lit = '{32'h00503283, 32'h00603303, 32'h00703383, 32'h007302B3};
    finish_scenario("basic", 9, lit);
    check("basic_model_latency", 32'(mode_cycles), 32'(1 + nr + 1 + CHECK_CYCLES));
    tick(2);

    // Back-pressure for three cycles while the rs1 restore is offered.
    begin_scenario(32'h007302B3, nr);
    voter_state = 3'b010;
    tick(1);
    voter_state = 3'b000;
    tick(2);
    rollback_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_bit("stall_rs1_valid", rollback_valid, 1'b1);
      check("stall_rs1_word", rollback_instr, 32'h00603303);
    end
    @(posedge clk);
    #1;
    rollback_ready = 1'b1;
    finish_scenario("stall", 12, lit);
    check("stall_cycles", 32'(stall_cycles), 32'd3);
    tick(2);

    // All register fields are x0: straight to replay.
    begin_scenario(32'h00000013, nr);
    voter_state = 3'b001;
    tick(2);
    voter_state = 3'b000;
    lit = '{32'h00000013};
    finish_scenario("nop", 6, lit);
    tick(2);

    // rs2 field is zero; a fresh voter edge during restore must be ignored.
    begin_scenario(32'h00028093, nr);
    voter_state = 3'b010;
    tick(1);
    voter_state = 3'b000;
    tick(1);
    voter_state = 3'b100;
    tick(1);
    voter_state = 3'b000;
    lit = '{32'h00103083, 32'h00503283, 32'h00028093};
    finish_scenario("partial", 8, lit);
    check("partial_model_latency", 32'(mode_cycles), 32'(1 + nr + 1 + CHECK_CYCLES));
    tick(2);

    // Fault in every check window: two retries, then sticky FAIL.
    begin_scenario(32'h007302B3, nr);
    voter_state = 3'b010;
    tick(2);
    voter_state = 3'b000;
    for (int r = 1; r <= 3; r++) begin
      int n = 0;
      while (hs_count < 4 * r && n < 100) begin
        @(negedge clk);
        #1;
        n++;
      end
      if (n >= 100) fail_timeout("retry_wait");
      tick(1);
      check_bit("retry_check_no_valid", rollback_valid, 1'b0);
      check_bit("retry_check_mode", recovery_mode, 1'b1);
      voter_state = 3'b001;
      if (r < 3) nr = push_expected(rd_instr);
      tick(1);
      voter_state = 3'b000;
      if (r < 3) begin
        check("retry_cnt", 32'(retry_cnt), 32'(r));
        check_bit("retry_not_failed", recovery_fail, 1'b0);
      end
    end
    check_bit("fail_flag", recovery_fail, 1'b1);
    check_bit("fail_core_hold", core_hold, 1'b1);
    check_bit("fail_valid_low", rollback_valid, 1'b0);
    for (int i = 0; i < 6; i++) begin
      voter_state = (i % 2 == 0) ? 3'b111 : 3'b000;
      tick(1);
      check_bit("fail_sticky", recovery_fail, 1'b1);
    end
    check("fail_queue_empty", 32'(exp_q.size()), 32'h0);
    voter_state = 3'b000;
    #2;
    rst_in = 1'b0;
    #1;
    check_zero_outputs("fail_async_reset");
    tick(2);
    rst_in = 1'b1;
    tick(3);

    // Reset in the middle of the rs2 restore with the fault still held.
    begin_scenario(32'h007302B3, nr);
    voter_state = 3'b010;
    tick(4);
    check_bit("rs2_valid", rollback_valid, 1'b1);
    check("rs2_word", rollback_instr, 32'h00703383);
    #2;
    rst_in = 1'b0;
    #1;
    check_zero_outputs("mid_async_reset");
    exp_q.delete();
    tick(2);
    rst_in = 1'b1;
    mode_cycles = 0;
    tick(10);
    check("held_fault_no_retrigger", 32'(mode_cycles), 32'h0);
    check_zero_outputs("held_fault_idle");
    voter_state = 3'b000;
    tick(2);
    begin_scenario(32'h007302B3, nr);
    voter_state = 3'b010;
    tick(2);
    voter_state = 3'b000;
    lit = '{32'h00503283, 32'h00603303, 32'h00703383, 32'h007302B3};
    finish_scenario("after_reset_refault", 9, lit);
    tick(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
